flash_cmd_sched: RTL

- Round-robin command scheduler in front of the NAND flash controller core.
- Shares the single nfc_cmd/nfc_strt/RWA/BF_sel command port between NREQ requesters (host DMA, test sequencer, bad-block manager, ...).
- Sequences exactly one flash operation at a time: start pulse, completion wait, error capture.
- Returns a one-cycle response with status to the granted requester.

---
 rtl/flash_cmd_sched.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/flash_cmd_sched.sv
// flash_cmd_sched
// ---------------
// Round-robin command scheduler in front of the NAND flash controller core.
// Several requesters share the single nfc_cmd/nfc_strt/RWA/BF_sel port.
// The block runs one flash operation at a time: it grants a requester,
// validates the command, issues the start pulse, waits for the core's
// done handshake (drop, then rise), and returns a one-cycle response
// with error status to the granted requester.
//
// Build option:
//   FLASH_SCHED_TIMEOUT_EN - when defined, a 16-bit watchdog aborts an
//   operation that waits TMO_CYC cycles for the core. The scheduler then
//   strobes a reset command into the core and responds with rsp_err[4]=1.
//   When undefined, the wait states wait indefinitely and rsp_err[4]=0.
//
// Ports:
//   clk, rst          system clock, asynchronous active-low reset
//   req/req_cmd/req_addr  per-requester request level, 3-bit command and
//                     16-bit row address (slice i = [3i+2:3i] / [16i+15:16i])
//   gnt               one-hot grant pulse, combinational in the IDLE cycle
//   rsp_valid/rsp_id/rsp_err  one-cycle response {tmo,bad_cmd,RErr,EErr,PErr}
//   busy              operation in progress (grant acceptance to response)
//   nfc_cmd/nfc_strt/RWA/BF_sel  command port toward the flash core
//   nfc_done, PErr, EErr, RErr   completion level and error flags from core
//
// State table:
//   IDLE    | arbitrate; grant accepted at the clock edge
//   CHECK   | validate the latched command
//   START   | nfc_strt pulse with command and row address
//   WAIT_LO | wait for nfc_done=0 (core acknowledge)
//   WAIT_HI | wait for nfc_done=1, capture error flags
//   TMO_RST | watchdog expired: reset command strobe to the core
//   RESP    | rsp_valid pulse back to the owner

module flash_cmd_sched #(
  parameter int NREQ    = 4,
  parameter int TMO_CYC = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [3*NREQ-1:0]    req_cmd,
  input  logic [16*NREQ-1:0]   req_addr,
  output logic [NREQ-1:0]      gnt,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_id,
  output logic [4:0]           rsp_err,
  output logic                 busy,
  output logic [2:0]           nfc_cmd,
  output logic                 nfc_strt,
  output logic [15:0]          RWA,
  output logic                 BF_sel,
  input  logic                 nfc_done,
  input  logic                 PErr,
  input  logic                 EErr,
  input  logic                 RErr
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CHECK   = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_WAIT_LO = 3'd3;
  localparam logic [2:0] ST_WAIT_HI = 3'd4;
  localparam logic [2:0] ST_RESP    = 3'd5;
  localparam logic [2:0] ST_TMO_RST = 3'd6;

  localparam logic [2:0] CMD_RESET  = 3'b011;

  function automatic logic cmd_valid(input logic [2:0] c);
    return (c == 3'b001) || (c == 3'b010) || (c == 3'b011) ||
           (c == 3'b100) || (c == 3'b101);
  endfunction

  // Commands that move data through the page buffer.
  function automatic logic cmd_uses_buf(input logic [2:0] c);
    return (c == 3'b001) || (c == 3'b010) || (c == 3'b101);
  endfunction

  logic [2:0]  state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  id_q, id_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [15:0] addr_q, addr_d;
  logic [4:0]  err_q, err_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic [2:0]  rsp_id_q, rsp_id_d;
  logic [4:0]  rsp_err_q, rsp_err_d;
  logic        busy_q, busy_d;
  logic [2:0]  nfc_cmd_q, nfc_cmd_d;
  logic        nfc_strt_q, nfc_strt_d;
  logic [15:0] rwa_q, rwa_d;
  logic        bf_sel_q, bf_sel_d;

  logic [7:0]  req_pad;
  logic [3:0]  cand;
  logic        arb_hit;
  logic [2:0]  arb_idx;
  logic        grant;
  logic        tmo_hit;
  logic        in_wait;

  assign in_wait = (state_q == ST_WAIT_LO) || (state_q == ST_WAIT_HI);

  // ---------------------------------------------------------------------
  // Round-robin arbitration: first requester at or after ptr_q, cyclically.
  // ---------------------------------------------------------------------
  always_comb begin
    req_pad = '0;
    req_pad[NREQ-1:0] = req;
  end

  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + 4'(k);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      if (!arb_hit && req_pad[cand[2:0]]) begin
        arb_hit = 1'b1;
        arb_idx = cand[2:0];
      end
    end
  end

  // Grant is qualified by rst so that gnt reads 0 while reset is held,
  // even though it is a combinational decode of req in IDLE.
  assign grant = rst && (state_q == ST_IDLE) && arb_hit;

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt[i] = grant && (arb_idx == 3'(i));
    end
  end

  // ---------------------------------------------------------------------
  // Operation watchdog
  // ---------------------------------------------------------------------
`ifdef FLASH_SCHED_TIMEOUT_EN
  // Down-counter loaded in START; expiry when it reads zero in a wait
  // state, which is exactly TMO_CYC wait cycles after START.
  localparam logic [15:0] TMO_LOAD = 16'(TMO_CYC - 1);

  logic [15:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == ST_START) begin
      wdog_d = TMO_LOAD;
    end else if (in_wait && (wdog_q != 16'd0)) begin
      wdog_d = wdog_q - 16'd1;
    end
  end

  assign tmo_hit = in_wait && (wdog_q == 16'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic [15:0] unused_tmo;
  assign unused_tmo = 16'(TMO_CYC);
  assign tmo_hit    = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          id_d  = arb_idx;
          ptr_d = (arb_idx == 3'(NREQ - 1)) ? 3'd0 : arb_idx + 3'd1;
          for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == 3'(i)) begin
              cmd_d  = req_cmd[3*i +: 3];
              addr_d = req_addr[16*i +: 16];
            end
          end
          err_d   = '0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!cmd_valid(cmd_q)) begin
          err_d   = 5'b01000;
          state_d = ST_RESP;
        end else begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!nfc_done) begin
          state_d = ST_WAIT_HI;
        end else if (tmo_hit) begin
          state_d = ST_TMO_RST;
        end
      end
      ST_WAIT_HI: begin
        // A completion on the expiry cycle still counts as a completion.
        if (nfc_done) begin
          err_d   = {2'b00, RErr, EErr, PErr};
          state_d = ST_RESP;
        end else if (tmo_hit) begin
          state_d = ST_TMO_RST;
        end
      end
      ST_TMO_RST: begin
        err_d   = 5'b10000;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with
  // state_q on the following cycle and are glitch-free toward the core.
  always_comb begin
    nfc_strt_d  = (state_d == ST_START) || (state_d == ST_TMO_RST);
    nfc_cmd_d   = nfc_cmd_q;
    rwa_d       = rwa_q;
    if (state_d == ST_START) begin
      nfc_cmd_d = cmd_d;
      rwa_d     = addr_d;
    end else if (state_d == ST_TMO_RST) begin
      nfc_cmd_d = CMD_RESET;
    end
    bf_sel_d    = ((state_d == ST_START) || (state_d == ST_WAIT_LO) ||
                   (state_d == ST_WAIT_HI)) && cmd_uses_buf(cmd_d);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_RESP);
    rsp_valid_d = (state_d == ST_RESP);
    rsp_id_d    = (state_d == ST_RESP) ? id_d  : 3'd0;
    rsp_err_d   = (state_d == ST_RESP) ? err_d : 5'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      err_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_err_q   <= '0;
      busy_q      <= 1'b0;
      nfc_cmd_q   <= '0;
      nfc_strt_q  <= 1'b0;
      rwa_q       <= '0;
      bf_sel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      nfc_cmd_q   <= nfc_cmd_d;
      nfc_strt_q  <= nfc_strt_d;
      rwa_q       <= rwa_d;
      bf_sel_q    <= bf_sel_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign nfc_cmd   = nfc_cmd_q;
  assign nfc_strt  = nfc_strt_q;
  assign RWA       = rwa_q;
  assign BF_sel    = bf_sel_q;

endmodule
